// File: rtl/f3m_pkg.sv
// Shared definitions for the GF(3^M) Frobenius unit: digit encodings,
// GF(3) digit arithmetic helpers and the controller state type.
package f3m_pkg;

    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Negation swaps the two bits of a digit (1 <-> 2, 0 stays 0).
    function automatic logic [1:0] f3_neg(input logic [1:0] d);
        return {d[0], d[1]};
    endfunction

    // Sum of two legal digits, result is always a legal digit.
    function automatic logic [1:0] f3_add(input logic [1:0] x,
                                          input logic [1:0] y);
        logic [1:0] r;
        if (x == F3_ZERO)      r = y;
        else if (y == F3_ZERO) r = x;
        else if (x == y)       r = f3_neg(x);
        else                   r = F3_ZERO;
        return r;
    endfunction

    // The unused code 11 is treated as zero.
    function automatic logic [1:0] f3_clean(input logic [1:0] d);
        return (d == 2'b11) ? F3_ZERO : d;
    endfunction

endpackage

// File: rtl/f3m_cube_p.sv
// Combinational cubing in GF(3^M) modulo x^M + x^K + 2.
// Ports: a_i operand (2*M bits, 2 bits per digit), c_o = a_i^3.
module f3m_cube_p
    import f3m_pkg::*;
#(
    parameter int M = 97,
    parameter int K = 12
) (
    input  logic [2*M-1:0] a_i,
    output logic [2*M-1:0] c_o
);

    localparam int W = 3*M - 2;

    // Spread digit i to x^(3i), then fold every term at or above x^M
    // downward using x^M == -x^K + 1. Folding from the top keeps each
    // contribution landing on a lower, not yet folded, position. All
    // indices are constants after unrolling, so this is wiring plus
    // small GF(3) adders.
    function automatic logic [2*M-1:0] cube(input logic [2*M-1:0] x);
        logic [1:0]     t [W];
        logic [2*M-1:0] r;
        for (int e = 0; e < W; e++) t[e] = F3_ZERO;
        for (int i = 0; i < M; i++) t[3*i] = x[2*i +: 2];
        for (int e = W - 1; e >= M; e--) begin
            t[e-M+K] = f3_add(t[e-M+K], f3_neg(t[e]));
            t[e-M]   = f3_add(t[e-M], t[e]);
        end
        r = '0;
        for (int i = 0; i < M; i++) r[2*i +: 2] = t[i];
        return r;
    endfunction

    assign c_o = cube(a_i);

endmodule

// File: rtl/f3m_multi_cube.sv
// Sequential Frobenius unit: c = a^(3^n) in GF(3^M), one cube per RUN cycle.
// Ports: clk, reset (sync, active-high), start/n/a request, busy, done pulse,
// c result. Define F3M_DOUBLE_CUBE_EN to apply two cubes per RUN cycle.
module f3m_multi_cube
    import f3m_pkg::*;
#(
    parameter int M  = 97,
    parameter int K  = 12,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic [2*M-1:0] a,
    output logic          busy,
    output logic          done,
    output logic [2*M-1:0] c
);

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*M-1:0] acc_q, acc_d;
    logic [2*M-1:0] c_q;
    logic [2*M-1:0] a_clean;
    logic [2*M-1:0] cube1;
    logic           accept;

    f3m_cube_p #(.M(M), .K(K)) u_cube0 (.a_i(acc_q), .c_o(cube1));

`ifdef F3M_DOUBLE_CUBE_EN
    logic [2*M-1:0] cube2;
    f3m_cube_p #(.M(M), .K(K)) u_cube1 (.a_i(cube1), .c_o(cube2));
`endif

    // A start in the DONE cycle is taken; only RUN ignores requests.
    assign accept = start && (state_q != RUN);

    always_comb begin
        a_clean = '0;
        for (int i = 0; i < M; i++) a_clean[2*i +: 2] = f3_clean(a[2*i +: 2]);
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if (accept) begin
            acc_d   = a_clean;
            count_d = n;
        end else if (state_q == RUN) begin
`ifdef F3M_DOUBLE_CUBE_EN
            if (count_q >= CW'(2)) begin
                acc_d   = cube2;
                count_d = count_q - CW'(2);
            end else begin
                acc_d   = cube1;
                count_d = (count_q != '0) ? count_q - CW'(1) : '0;
            end
`else
            acc_d   = cube1;
            count_d = (count_q != '0) ? count_q - CW'(1) : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start)                state_d = (n == '0) ? DONE : RUN;
                else if (state_q == DONE) state_d = IDLE;
            end
            RUN:     if (count_d == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE: ;
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // The result register loads on the edge entering DONE so c is
    // valid in the same cycle as the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            if (state_d == DONE) c_q <= acc_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_f3m_multi_cube.sv
// Directed bench for f3m_multi_cube with a Horner-multiply GF(3^M) model.
// Build with or without F3M_DOUBLE_CUBE_EN to match the RTL.
module tb_f3m_multi_cube;

    localparam int M  = 97;
    localparam int K  = 12;
    localparam int CW = 8;
    localparam int W  = 2*M;

    typedef logic [W-1:0] el_t;

    typedef struct {
        el_t   a;
        int    n;
        el_t   c;
        string name;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] n;
    el_t           a;
    logic          busy;
    logic          done;
    el_t           c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    f3m_multi_cube #(.M(M), .K(K), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n     (n),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    task automatic chk(input string name, input el_t got, input el_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input int nn);
`ifdef F3M_DOUBLE_CUBE_EN
        return (nn + 1) / 2 + 1;
`else
        return nn + 1;
`endif
    endfunction

    function automatic int gd(input el_t e, input int i);
        logic [1:0] d;
        d = e[2*i +: 2];
        return (d == 2'b01) ? 1 : ((d == 2'b10) ? 2 : 0);
    endfunction

    function automatic el_t sd(input el_t e, input int i, input int v);
        e[2*i +: 2] = (v == 1) ? 2'b01 : ((v == 2) ? 2'b10 : 2'b00);
        return e;
    endfunction

    // p * x reduced with x^M = -x^K + 1 = 2x^K + 1
    function automatic el_t mulx(input el_t p);
        el_t r;
        int  t;
        t = gd(p, M-1);
        r = p << 2;
        r = sd(r, 0, t);
        r = sd(r, K, (gd(r, K) + 2*t) % 3);
        return r;
    endfunction

    function automatic el_t mul(input el_t x, input el_t y);
        el_t acc;
        int  bi;
        acc = '0;
        for (int i = M-1; i >= 0; i--) begin
            acc = mulx(acc);
            bi = gd(y, i);
            if (bi != 0)
                for (int j = 0; j < M; j++)
                    acc = sd(acc, j, (gd(acc, j) + bi*gd(x, j)) % 3);
        end
        return acc;
    endfunction

    function automatic el_t model(input el_t x, input int cnt);
        el_t p;
        p = x;
        for (int i = 0; i < cnt; i++) p = mul(mul(p, p), p);
        return p;
    endfunction

    function automatic el_t rand_el();
        el_t e;
        e = '0;
        for (int i = 0; i < M; i++) e = sd(e, i, int'($urandom_range(0, 2)));
        return e;
    endfunction

    task automatic start_op(input el_t av, input int nv);
        a = av;
        n = CW'(nv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat counts observed cycles up to and including the done cycle;
    // nb counts cycles in that window where busy was low.
    task automatic wait_done(output int lat, output int nb);
        lat = 1;
        nb  = 0;
        while (1) begin
            if (!busy) nb++;
            if (done || lat >= 400) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t tv [8];
    el_t  one, x1, r, ra, a1, a2;
    int   lat, nb, seen;

    initial begin
        one = el_t'(1);
        x1  = el_t'(1) << 2;

        tv[0] = '{one, 5, one, "a1_n5"};
        tv[1] = '{x1, 1, el_t'(1) << 6, "x_n1"};
        tv[2] = '{x1, 4, el_t'(1) << 162, "x_n4"};
        r = rand_el();
        tv[3] = '{r, 97, r, "rand_n97"};
        r = rand_el();
        ra = r;
        ra[11:10] = 2'b11;
        r[11:10] = 2'b00;
        tv[4] = '{ra, 0, r, "n0_illegal"};
        r = rand_el();
        tv[5] = '{r, 3, model(r, 3), "rand_n3"};
        r = rand_el();
        tv[6] = '{r, 98, model(r, 1), "rand_n98"};
        tv[7] = '{el_t'(1) << 192, 2, model(el_t'(1) << 192, 2), "x96_n2"};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", el_t'(busy), el_t'(0));
        chk("rst_done", el_t'(done), el_t'(0));
        chk("rst_c", c, el_t'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            start_op(tv[i].a, tv[i].n);
            wait_done(lat, nb);
            chk({tv[i].name, "_c"}, c, tv[i].c);
            chk({tv[i].name, "_lat"}, el_t'(lat), el_t'(exp_lat(tv[i].n)));
            chk({tv[i].name, "_busy"}, el_t'(nb), el_t'(0));
            @(posedge clk);
            #1;
            chk({tv[i].name, "_idle"}, el_t'({busy, done}), el_t'(0));
            chk({tv[i].name, "_hold"}, c, tv[i].c);
        end

        // requests during RUN are ignored
        a1 = rand_el();
        start_op(a1, 6);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rand_el();
            n = CW'(i + 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done(lat, nb);
        chk("ign_c", c, model(a1, 6));
        chk("ign_lat", el_t'(lat + 3), el_t'(exp_lat(6)));
        @(posedge clk);
        #1;
        chk("ign_idle", el_t'({busy, done}), el_t'(0));

        // start in the DONE cycle is accepted back-to-back
        a1 = rand_el();
        a2 = rand_el();
        start_op(a1, 2);
        wait_done(lat, nb);
        chk("b2b_c1", c, model(a1, 2));
        start_op(a2, 1);
        chk("b2b_run", el_t'({busy, done}), el_t'(2'b10));
        wait_done(lat, nb);
        chk("b2b_c2", c, model(a2, 1));
        chk("b2b_lat", el_t'(lat), el_t'(exp_lat(1)));

        // reset in the middle of a long run
        start_op(rand_el(), 10);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", el_t'(busy), el_t'(0));
        chk("abort_c", c, el_t'(0));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_quiet", el_t'(seen), el_t'(0));
        start_op(x1, 1);
        wait_done(lat, nb);
        chk("after_rst_c", c, el_t'(1) << 6);
        chk("after_rst_lat", el_t'(lat), el_t'(exp_lat(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
